adc_pulse_detector: RTL and testbench
=====================================

// Module: adc_pulse_detector
// PURPOSE
//  Consumes one synchronised 14-bit ADC channel (a2da_data/a2db_data domain, sys_clk) and detects radiation pulses.
//  Tracks baseline, triggers on threshold, integrates each pulse, emits one event record per pulse over valid/ready.
//  Feeds the downstream event packer/FIFO. One instance per channel.
// PARAMETERS
//  DATA_W     14   ADC sample width
//  BASE_SHIFT 6    baseline EMA time constant = 2^BASE_SHIFT samples
//  SETTLE_CYC 1024 samples after reset with baseline updating and trigger disabled
//  MAX_LEN    256  max pulse length in samples; longer pulses are truncated
//  HOLDOFF    16   dead cycles after each pulse before re-arming
//  AREA_W     32   signed area accumulator width
// PORTS
//  sys_clk      in  1       system clock; all logic on rising edge
//  reset        in  1       synchronous, active-high reset
//  adc_data     in  DATA_W  sample, one per cycle
//  adc_or       in  1       ADC out-of-range flag aligned with adc_data
//  data_fmt     in  1       0 = offset binary, 1 = two's complement
//  threshold    in  DATA_W  trigger level above baseline (unsigned)
//  hyst         in  DATA_W  end level = threshold - hyst (clamp at 0)
//  evt_valid    out 1       event record valid
//  evt_ready    in  1       consumer accepts when valid&ready
//  evt_time     out 32      free-running sample counter at trigger sample
//  evt_peak     out DATA_W+1  signed max amplitude (sample - baseline)
//  evt_peak_idx out 8       sample offset of peak from trigger (0 = trigger)
//  evt_area     out AREA_W  signed sum of amplitudes over pulse
//  evt_len      out 9       samples in pulse (1..MAX_LEN)
//  evt_flags    out 2       [0] out-of-range seen, [1] truncated at MAX_LEN
//  drop_cnt     out 16      events lost to backpressure, saturating
// BEHAVIOUR
//  - Reset: all outputs 0; baseline acc 0; timestamp 0; FSM -> SETTLE. Reset mid-pulse discards the pulse, not counted as drop.
//  - Stage 1 (1 cycle): s1 <= signed(adc_data) (offset binary: MSB inverted); or1 <= adc_or. amp = s1 - baseline, DATA_W+1 bits signed.
//  - Baseline: acc (DATA_W+BASE_SHIFT signed); baseline = acc>>>BASE_SHIFT; acc += s1 - baseline, only in SETTLE/IDLE. Frozen otherwise.
//  - threshold/hyst sampled only in IDLE; stable for the whole pulse.
//  - FSM: SETTLE -(SETTLE_CYC samples)-> IDLE; IDLE -(amp>=threshold)-> PULSE; PULSE -(amp<end level or len==MAX_LEN)-> EMIT;
//    EMIT -(1 cycle)-> HOLD; HOLD -(HOLDOFF cycles)-> IDLE.
//  - Trigger sample: len=1, area=amp, peak=amp, idx=0, time=ts_cnt, flags[0]=or1. Each further PULSE sample with amp>=end: len++,
//    area+=amp (saturate at signed limits), peak updates on strict greater (first max wins), flags[0]|=or1.
//  - Ending sample (amp<end) is excluded from len/area. At len==MAX_LEN, next cycle -> EMIT with flags[1]=1.
//  - Latency: ending sample on adc_data at edge k -> evt_valid high after edge k+2.
//  - EMIT: if !evt_valid or (evt_valid&evt_ready) in the same cycle -> load record, evt_valid=1; else drop, drop_cnt++ (sat 0xFFFF).
//  - evt_valid holds, record stable, until handshake; cleared after the accepting edge if no new load.
//  - ts_cnt: 32-bit, +1 per cycle, wraps 0xFFFFFFFF -> 0.
// STRUCTURE
//  - Package adc_det_pkg: state enum {SETTLE,IDLE,PULSE,EMIT,HOLD}, DATA_W/AREA_W defaults, event record struct, flag bit indices.
//  - Sub-module adc_baseline_tracker (EMA accumulator, freeze input, baseline output); FSM/integrator/output reg in this module.
// TESTING
//  1 Reset held 4 cycles, random adc_data -> all outputs 0, evt_valid 0, no trigger during SETTLE_CYC.
//  2 fmt=0, flat 0x2000, thr=100 hyst=20, amps 150,300,200,90,70 -> len=4 peak=300 idx=1 area=740 flags=0, ts = trigger cycle.
//  3 evt_ready=0, two pulses -> first record stable, second dropped, drop_cnt=1; ready=1 -> single handshake, valid drops.
//  4 amp=500 for 300 samples, MAX_LEN=256 -> len=256 area=128000 flags[1]=1; no re-trigger until HOLDOFF then amp>=thr.
//  5 adc_or pulsed mid-pulse -> flags[0]=1; separate run: reset during PULSE -> no event, drop_cnt 0.
//  6 baseline step +50 (<thr) -> no trigger; baseline within 1 LSB of 50 after 8*2^BASE_SHIFT samples; area saturation at +2^31-1.

Source files
------------

// File: rtl/adc_det_pkg.sv
// Shared types for the ADC pulse detector: FSM states, event header record
// and flag bit positions.
package adc_det_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int AREA_W_DEF = 32;

  localparam int FLAG_OR    = 0;
  localparam int FLAG_TRUNC = 1;

  typedef enum logic [2:0] {
    SETTLE,
    IDLE,
    PULSE,
    EMIT,
    HOLD
  } state_t;

  // Width-independent part of an event; peak and area travel alongside
  // because their widths follow the instance parameters.
  typedef struct packed {
    logic [31:0] time_stamp;
    logic [7:0]  peak_idx;
    logic [8:0]  len;
    logic [1:0]  flags;
  } evt_hdr_t;

endpackage

// File: rtl/adc_baseline_tracker.sv
// Exponential moving average of the signed sample stream; the accumulator
// holds baseline * 2^BASE_SHIFT so the baseline is simply its upper bits.
module adc_baseline_tracker #(
  parameter int DATA_W     = 14,
  parameter int BASE_SHIFT = 6
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     freeze_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [DATA_W-1:0] baseline_o
);

  localparam int ACC_W = DATA_W + BASE_SHIFT;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] err;

  assign baseline_o = acc_q[ACC_W-1:BASE_SHIFT];
  assign err = {{BASE_SHIFT{sample_i[DATA_W-1]}}, sample_i}
             - {{BASE_SHIFT{baseline_o[DATA_W-1]}}, baseline_o};
  assign acc_d = freeze_i ? acc_q : acc_q + err;

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/adc_pulse_detector.sv
// Per-channel pulse detector: baseline subtraction, threshold trigger with
// hysteresis, pulse integration and one buffered event record per pulse.
module adc_pulse_detector
  import adc_det_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BASE_SHIFT = 6,
  parameter int SETTLE_CYC = 1024,
  parameter int MAX_LEN    = 256,
  parameter int HOLDOFF    = 16,
  parameter int AREA_W     = AREA_W_DEF
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_or,
  input  logic              data_fmt,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] hyst,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [31:0]       evt_time,
  output logic [DATA_W:0]   evt_peak,
  output logic [7:0]        evt_peak_idx,
  output logic [AREA_W-1:0] evt_area,
  output logic [8:0]        evt_len,
  output logic [1:0]        evt_flags,
  output logic [15:0]       drop_cnt
);

  localparam int CNT_MAX = (SETTLE_CYC > HOLDOFF) ? SETTLE_CYC : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic signed [AREA_W-1:0] AREA_MAX = {1'b0, {(AREA_W-1){1'b1}}};
  localparam logic signed [AREA_W-1:0] AREA_MIN = {1'b1, {(AREA_W-1){1'b0}}};

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]         end_q, end_d, end_lvl;
  evt_hdr_t                  cur_q, cur_d, out_q;
  logic signed [AREA_W-1:0]  area_q, area_d, out_area_q;
  logic signed [DATA_W:0]    peak_q, peak_d, out_peak_q;
  logic                      valid_q;
  logic [15:0]               drop_q;
  logic [31:0]               ts_q;
  logic signed [DATA_W-1:0]  s1_q, s1_d, baseline;
  logic                      or1_q;
  logic                      freeze, load, drop;

  logic signed [DATA_W:0]    amp;
  logic signed [DATA_W+1:0]  amp_x, thr_x, end_x;
  logic signed [AREA_W-1:0]  amp_ext, area_sat;
  logic signed [AREA_W:0]    area_sum;

  // Offset binary becomes two's complement by flipping the MSB.
  assign s1_d = data_fmt ? adc_data : {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};

  adc_baseline_tracker #(
    .DATA_W     (DATA_W),
    .BASE_SHIFT (BASE_SHIFT)
  ) u_baseline (
    .clk        (sys_clk),
    .srst       (reset),
    .freeze_i   (freeze),
    .sample_i   (s1_q),
    .baseline_o (baseline)
  );

  assign amp     = {s1_q[DATA_W-1], s1_q} - {baseline[DATA_W-1], baseline};
  assign amp_x   = {amp[DATA_W], amp};
  assign thr_x   = {2'b00, threshold};
  assign end_x   = {2'b00, end_q};
  assign end_lvl = (threshold > hyst) ? threshold - hyst : '0;

  assign amp_ext  = {{(AREA_W-DATA_W-1){amp[DATA_W]}}, amp};
  assign area_sum = {area_q[AREA_W-1], area_q} + {amp_ext[AREA_W-1], amp_ext};
  assign area_sat = (area_sum[AREA_W] != area_sum[AREA_W-1])
                  ? (area_sum[AREA_W] ? AREA_MIN : AREA_MAX)
                  : area_sum[AREA_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    cur_d   = cur_q;
    area_d  = area_q;
    peak_d  = peak_q;
    freeze  = 1'b1;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      SETTLE: begin
        freeze = 1'b0;
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        end_d = end_lvl;
        // The trigger sample belongs to the pulse, so it must not leak into the baseline.
        if (amp_x >= thr_x) begin
          state_d               = PULSE;
          cur_d.time_stamp      = ts_q;
          cur_d.peak_idx        = '0;
          cur_d.len             = 9'd1;
          cur_d.flags           = '0;
          cur_d.flags[FLAG_OR]  = or1_q;
          area_d                = amp_ext;
          peak_d                = amp;
        end else begin
          freeze = 1'b0;
        end
      end
      PULSE: begin
        if (cur_q.len == 9'(MAX_LEN)) begin
          state_d                 = EMIT;
          cur_d.flags[FLAG_TRUNC] = 1'b1;
        end else if (amp_x < end_x) begin
          state_d = EMIT;
        end else begin
          cur_d.len            = cur_q.len + 9'd1;
          cur_d.flags[FLAG_OR] = cur_q.flags[FLAG_OR] | or1_q;
          area_d               = area_sat;
          if (amp > peak_q) begin
            peak_d         = amp;
            cur_d.peak_idx = cur_q.len[7:0];
          end
        end
      end
      EMIT: begin
        state_d = HOLD;
        cnt_d   = '0;
        if (!valid_q || evt_ready) begin
          load = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= SETTLE;
      cnt_q      <= '0;
      end_q      <= '0;
      cur_q      <= '0;
      area_q     <= '0;
      peak_q     <= '0;
      out_q      <= '0;
      out_area_q <= '0;
      out_peak_q <= '0;
      valid_q    <= 1'b0;
      drop_q     <= '0;
      ts_q       <= '0;
      s1_q       <= '0;
      or1_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      cur_q   <= cur_d;
      area_q  <= area_d;
      peak_q  <= peak_d;
      ts_q    <= ts_q + 32'd1;
      s1_q    <= s1_d;
      or1_q   <= adc_or;
      if (load) begin
        out_q      <= cur_q;
        out_area_q <= area_q;
        out_peak_q <= peak_q;
        valid_q    <= 1'b1;
      end else if (valid_q && evt_ready) begin
        valid_q <= 1'b0;
      end
      if (drop && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign evt_valid    = valid_q;
  assign evt_time     = out_q.time_stamp;
  assign evt_peak     = out_peak_q;
  assign evt_peak_idx = out_q.peak_idx;
  assign evt_area     = out_area_q;
  assign evt_len      = out_q.len;
  assign evt_flags    = out_q.flags;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_adc_pulse_detector.sv
// Directed bench for adc_pulse_detector; area width is narrowed so that
// accumulator saturation is reachable within MAX_LEN samples.
module tb_adc_pulse_detector;

  localparam int SETTLE = 1024;
  localparam logic [13:0] FLAT = 14'h2000;

  logic        sys_clk = 1'b0;
  logic        reset, adc_or, data_fmt, evt_ready;
  logic [13:0] adc_data, threshold, hyst;
  logic        evt_valid;
  logic [31:0] evt_time;
  logic [14:0] evt_peak;
  logic [7:0]  evt_peak_idx;
  logic [17:0] evt_area;
  logic [8:0]  evt_len;
  logic [1:0]  evt_flags;
  logic [15:0] drop_cnt;

  int checks, failures, cyc, n_evt;
  longint t_exp, t4;

  adc_pulse_detector #(.AREA_W(18)) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .adc_data     (adc_data),
    .adc_or       (adc_or),
    .data_fmt     (data_fmt),
    .threshold    (threshold),
    .hyst         (hyst),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_time     (evt_time),
    .evt_peak     (evt_peak),
    .evt_peak_idx (evt_peak_idx),
    .evt_area     (evt_area),
    .evt_len      (evt_len),
    .evt_flags    (evt_flags),
    .drop_cnt     (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // cyc equals the DUT timestamp after each edge taken out of reset.
  task automatic step();
    @(posedge sys_clk);
    #1;
    if (reset) cyc = 0;
    else       cyc++;
  endtask

  function automatic logic [13:0] ob(input int a);
    return 14'(8192 + a);
  endfunction

  task automatic drive(input logic [13:0] v);
    adc_data = v;
    step();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (evt_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(tag, longint'(evt_valid), 1);
  endtask

  task automatic accept();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("valid_after_accept", longint'(evt_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    reset = 1'b1; adc_or = 1'b0; data_fmt = 1'b0; evt_ready = 1'b0;
    threshold = 14'd100; hyst = 14'd20; adc_data = '0;

    // Reset with random samples.
    for (int i = 0; i < 4; i++) begin
      adc_data = 14'($urandom);
      step();
    end
    check("rst_valid", longint'(evt_valid), 0);
    check("rst_time",  longint'(evt_time), 0);
    check("rst_peak",  longint'(evt_peak), 0);
    check("rst_idx",   longint'(evt_peak_idx), 0);
    check("rst_area",  longint'(evt_area), 0);
    check("rst_len",   longint'(evt_len), 0);
    check("rst_flags", longint'(evt_flags), 0);
    check("rst_drop",  longint'(drop_cnt), 0);

    // Settling: a large pulse early on must not trigger.
    reset = 1'b0;
    n_evt = 0;
    for (int i = 0; i < SETTLE + 40; i++) begin
      drive((i >= 20 && i < 30) ? ob(1000) : FLAT);
      if (evt_valid) n_evt++;
    end
    check("settle_no_trigger", n_evt, 0);

    // Basic pulse: 150,300,200,90 counted, 70 ends it (end level 80).
    drive(ob(150)); t_exp = cyc;
    drive(ob(300)); drive(ob(200)); drive(ob(90)); drive(ob(70));
    drive(FLAT); check("lat_k1_valid", longint'(evt_valid), 0);
    drive(FLAT); check("lat_k2_valid", longint'(evt_valid), 1);
    check("p1_len",   longint'(evt_len), 4);
    check("p1_peak",  longint'(evt_peak), 300);
    check("p1_idx",   longint'(evt_peak_idx), 1);
    check("p1_area",  longint'(evt_area), 740);
    check("p1_flags", longint'(evt_flags), 0);
    check("p1_time",  longint'(evt_time), t_exp);
    accept();

    // Backpressure: second pulse dropped while the first is held.
    repeat (20) drive(FLAT);
    drive(ob(150)); t_exp = cyc;
    drive(ob(250)); drive(FLAT);
    wait_valid("bp_first_valid");
    repeat (25) drive(FLAT);
    drive(ob(120)); drive(FLAT);
    repeat (5) drive(FLAT);
    check("bp_drop_cnt", longint'(drop_cnt), 1);
    check("bp_valid",    longint'(evt_valid), 1);
    check("bp_len",      longint'(evt_len), 2);
    check("bp_area",     longint'(evt_area), 400);
    check("bp_time",     longint'(evt_time), t_exp);
    accept();
    drive(FLAT);
    check("bp_no_reload", longint'(evt_valid), 0);

    // Long pulse: truncation at 256, then re-trigger exactly after holdoff.
    repeat (20) drive(FLAT);
    for (int i = 0; i < 300; i++) begin
      evt_ready = (i == 263);
      drive(ob(500));
      if (i == 0) t4 = cyc;
      if (i == 262) begin
        check("trunc_valid", longint'(evt_valid), 1);
        check("trunc_len",   longint'(evt_len), 256);
        check("trunc_area",  longint'(evt_area), 128000);
        check("trunc_flags", longint'(evt_flags), 2);
        check("trunc_peak",  longint'(evt_peak), 500);
        check("trunc_time",  longint'(evt_time), t4);
      end
      if (i == 263) check("trunc_accepted", longint'(evt_valid), 0);
    end
    evt_ready = 1'b0;
    drive(FLAT);
    wait_valid("retrig_valid");
    check("retrig_time", longint'(evt_time), t4 + 274);
    check("retrig_len",  longint'(evt_len), 26);
    check("retrig_area", longint'(evt_area), 13000);
    check("retrig_flags", longint'(evt_flags), 0);
    accept();

    // Two's complement input with out-of-range mid-pulse.
    repeat (20) drive(FLAT);
    data_fmt = 1'b1;
    repeat (3) drive(14'd0);
    drive(14'd200); t_exp = cyc;
    adc_or = 1'b1; drive(14'd220);
    adc_or = 1'b0; drive(14'd210);
    drive(14'd200); drive(14'd0);
    wait_valid("or_valid");
    check("or_flags", longint'(evt_flags), 1);
    check("or_len",   longint'(evt_len), 4);
    check("or_area",  longint'(evt_area), 830);
    check("or_peak",  longint'(evt_peak), 220);
    check("or_idx",   longint'(evt_peak_idx), 1);
    check("or_time",  longint'(evt_time), t_exp);
    accept();
    data_fmt = 1'b0;
    repeat (20) drive(FLAT);

    // Reset while a pulse is in progress: nothing may come out.
    drive(ob(200)); drive(ob(220));
    reset = 1'b1;
    drive(ob(220)); drive(FLAT);
    reset = 1'b0;
    n_evt = 0;
    for (int i = 0; i < SETTLE + 20; i++) begin
      drive(FLAT);
      if (evt_valid) n_evt++;
    end
    check("rstpulse_no_event", n_evt, 0);
    check("rstpulse_drop",     longint'(drop_cnt), 0);

    // Area saturation: 20 x 8000 exceeds 2^17-1.
    for (int i = 0; i < 20; i++) drive(ob(8000));
    drive(FLAT);
    wait_valid("sat_valid");
    check("sat_area", longint'(evt_area), 131071);
    check("sat_len",  longint'(evt_len), 20);
    check("sat_peak", longint'(evt_peak), 8000);
    accept();
    repeat (20) drive(FLAT);

    // Baseline step of +50 below threshold: no trigger, baseline settles to 50.
    n_evt = 0;
    for (int i = 0; i < 512; i++) begin
      drive(ob(50));
      if (evt_valid) n_evt++;
    end
    check("step_no_trigger", n_evt, 0);
    drive(ob(250)); drive(ob(50));
    wait_valid("step_valid");
    check("step_peak", longint'(evt_peak), 200);
    check("step_len",  longint'(evt_len), 1);
    check("step_area", longint'(evt_area), 200);
    accept();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
